// File: rtl/beam_pkg.sv
// Shared types and sizing for the beam weight sequencer.
//   W_BITS       width of one signed beam weight
//   DEPTH / AW   default table size and address width
//   DWELL_BITS   default dwell counter width
//   weight_set_t one atomic set of the four beam weights, cos1 in the MSBs
//   state_t      sequencer states
package beam_pkg;

    localparam int W_BITS     = 5;
    localparam int DEPTH      = 16;
    localparam int AW         = 4;
    localparam int DWELL_BITS = 16;

    typedef struct packed {
        logic signed [W_BITS-1:0] cos1;
        logic signed [W_BITS-1:0] sin1;
        logic signed [W_BITS-1:0] cos2;
        logic signed [W_BITS-1:0] sin2;
    } weight_set_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/beam_weight_table.sv
// DEPTH-entry register file of weight sets.
//   clock, reset  rising-edge clock, asynchronous active-high reset (clears all entries)
//   wr_en         write strobe, wr_addr/wr_data written on the rising edge
//   rd_addr       combinational read address, rd_data the selected entry
module beam_weight_table
    import beam_pkg::*;
#(
    parameter int DEPTH = beam_pkg::DEPTH,
    parameter int AW    = beam_pkg::AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  weight_set_t   wr_data,
    input  logic [AW-1:0] rd_addr,
    output weight_set_t   rd_data
);

    weight_set_t mem [DEPTH];

    // NOTE: the table is reset on purpose so a sweep of unwritten entries
    // drives known zero weights; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking assignments for all state so every flop
                // samples pre-edge values regardless of statement order.
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/beam_weight_sequencer.sv
// Steps the two-beam weight outputs through a host-loaded table.
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   cfg_wr_*             valid/ready table write port, accepted only in IDLE
//   cfg_len/dwell/loop   sweep shape, captured into shadow registers on start
//   start, stop          begin (IDLE only) / abort (RUN only) a sweep
//   w_cos_1..w_sin_2     registered weights, all four change on the same edge
//   w_update             one-cycle pulse on every weight change
//   busy, step_idx       sweep in progress / table index driving the outputs
module beam_weight_sequencer
    import beam_pkg::*;
#(
    parameter int DEPTH      = beam_pkg::DEPTH,
    parameter int AW         = beam_pkg::AW,
    parameter int DWELL_BITS = beam_pkg::DWELL_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_wr_valid,
    output logic                  cfg_wr_ready,
    input  logic [AW-1:0]         cfg_wr_addr,
    input  logic [4*W_BITS-1:0]   cfg_wr_data,
    input  logic [AW-1:0]         cfg_len,
    input  logic [DWELL_BITS-1:0] cfg_dwell,
    input  logic                  cfg_loop,
    input  logic                  start,
    input  logic                  stop,
    output logic [W_BITS-1:0]     w_cos_1,
    output logic [W_BITS-1:0]     w_sin_1,
    output logic [W_BITS-1:0]     w_cos_2,
    output logic [W_BITS-1:0]     w_sin_2,
    output logic                  w_update,
    output logic                  busy,
    output logic [AW-1:0]         step_idx
);

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         len_q, len_d;
    logic [AW-1:0]         step_q, step_d;
    logic [DWELL_BITS-1:0] cnt_q, cnt_d;
    logic [DWELL_BITS-1:0] dwell_q, dwell_d;
    logic                  loop_q, loop_d;
    logic                  last_q, last_d;     // final entry of a one-shot sweep is showing
    logic                  upd_q, upd_d;
    weight_set_t           wts_q, wts_d;
    weight_set_t           rd_data;
    logic                  wr_en;

    assign cfg_wr_ready = (state_q == IDLE);
    assign wr_en        = cfg_wr_valid & cfg_wr_ready;

    beam_weight_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (cfg_wr_addr),
        .wr_data (weight_set_t'(cfg_wr_data)),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            last_q  <= 1'b0;
            upd_q   <= 1'b0;
            wts_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            last_q  <= last_d;
            upd_q   <= upd_d;
            wts_q   <= wts_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        last_d  = last_q;
        upd_d   = 1'b0;
        wts_d   = wts_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    len_d   = cfg_len;
                    dwell_d = (cfg_dwell == '0) ? DWELL_BITS'(1) : cfg_dwell;
                    loop_d  = cfg_loop;
                    idx_d   = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_BITS'(1);
                end else if (last_q) begin
                    // final entry has been held for its full dwell
                    state_d = IDLE;
                end else begin
                    wts_d  = rd_data;
                    upd_d  = 1'b1;
                    step_d = idx_q;
                    cnt_d  = dwell_q - DWELL_BITS'(1);
                    if (idx_q < len_q) begin
                        idx_d = idx_q + AW'(1);
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        last_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_cos_1  = wts_q.cos1;
    assign w_sin_1  = wts_q.sin1;
    assign w_cos_2  = wts_q.cos2;
    assign w_sin_2  = wts_q.sin2;
    assign w_update = upd_q;
    assign busy     = (state_q == RUN);
    assign step_idx = step_q;

endmodule
